// File: rtl/grf_scoreboard_pkg.sv
// Shared constants and helpers for the decode-stage register file / scoreboard.
package grf_scoreboard_pkg;

  localparam int GRF_DATA_W   = 32;
  localparam int GRF_REG_NUM  = 32;
  localparam int GRF_RD_PORTS = 2;
  localparam int GRF_CNT_W    = 2;

  localparam string GRF_TRACE_FMT = "@%h: $%d <= %h";

  // Address width for a register count; a 2-entry file still needs one bit.
  function automatic int grf_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/grf_scoreboard_if.sv
// Read, issue and writeback signals between the pipeline stages and the scoreboard.
interface grf_scoreboard_if
  import grf_scoreboard_pkg::*;
#(
  parameter int DATA_W   = GRF_DATA_W,
  parameter int REG_NUM  = GRF_REG_NUM,
  parameter int RD_PORTS = GRF_RD_PORTS
);
  localparam int AW = grf_aw(REG_NUM);

  logic [RD_PORTS*AW-1:0]     rd_addr;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_busy;
  logic                       issue_valid;
  logic [AW-1:0]              issue_addr;
  logic                       issue_ready;
  logic                       wb_we;
  logic [AW-1:0]              wb_addr;
  logic [DATA_W-1:0]          wb_data;
  logic [31:0]                wb_pc;
  logic                       flush;

  modport master (
    output rd_addr, input rd_data, input rd_busy,
    output issue_valid, output issue_addr, input issue_ready,
    output wb_we, output wb_addr, output wb_data, output wb_pc,
    output flush
  );

  modport slave (
    input rd_addr, output rd_data, output rd_busy,
    input issue_valid, input issue_addr, output issue_ready,
    input wb_we, input wb_addr, input wb_data, input wb_pc,
    input flush
  );

endinterface

// File: rtl/grf_sb_counter.sv
// Saturating pending-write counter for one register; clr wins over inc/dec.
module grf_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             max,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  assign zero      = (count == '0);
  assign max       = (count == CNT_MAX);
  // A retire with nothing outstanding is an error unless flush masks it.
  assign underflow = dec && !inc && zero && !clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && !max) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && !zero) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/grf_scoreboard.sv
// Register file with write-through bypass and per-register pending-write scoreboard.
// Optional build macro GRF_TRACE_EN adds a $display writeback trace.
module grf_scoreboard
  import grf_scoreboard_pkg::*;
#(
  parameter int DATA_W   = GRF_DATA_W,
  parameter int REG_NUM  = GRF_REG_NUM,
  parameter int RD_PORTS = GRF_RD_PORTS,
  parameter int CNT_W    = GRF_CNT_W,
  localparam int AW      = grf_aw(REG_NUM)
) (
  input  logic              clk,
  input  logic              reset,
  grf_scoreboard_if.slave   bus,
  output logic              err_underflow,
  output logic              w_grf_we,
  output logic [AW-1:0]     w_grf_addr,
  output logic [DATA_W-1:0] w_grf_wdata,
  output logic [31:0]       w_inst_addr
);

  logic [DATA_W-1:0]  regs [REG_NUM];
  logic [CNT_W-1:0]   cnt  [REG_NUM];
  logic [REG_NUM-1:0] cnt_zero;
  logic [REG_NUM-1:0] cnt_max;
  logic [REG_NUM-1:0] cnt_uf;

  assign w_grf_we    = bus.wb_we && (bus.wb_addr != '0);
  assign w_grf_addr  = bus.wb_addr;
  assign w_grf_wdata = bus.wb_data;
  assign w_inst_addr = bus.wb_pc;

  // Register 0 has no counter: it never becomes pending.
  assign cnt[0]      = '0;
  assign cnt_zero[0] = 1'b1;
  assign cnt_max[0]  = 1'b0;
  assign cnt_uf[0]   = 1'b0;

  assign bus.issue_ready = (bus.issue_addr == '0) || !cnt_max[bus.issue_addr] ||
                           (bus.wb_we && (bus.wb_addr == bus.issue_addr));

  for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
    logic inc_r;
    logic dec_r;

    assign inc_r = bus.issue_valid && bus.issue_ready && !bus.flush &&
                   (bus.issue_addr == AW'(r));
    assign dec_r = bus.wb_we && (bus.wb_addr == AW'(r));

    grf_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc_r),
      .dec       (dec_r),
      .clr       (bus.flush),
      .count     (cnt[r]),
      .zero      (cnt_zero[r]),
      .max       (cnt_max[r]),
      .underflow (cnt_uf[r])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (w_grf_we) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_underflow <= 1'b0;
    end else if (|cnt_uf) begin
      err_underflow <= 1'b1;
    end
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = bus.rd_addr[i*AW +: AW];
    assign hit  = w_grf_we && (bus.wb_addr == addr);
    assign bus.rd_data[i*DATA_W +: DATA_W] = hit ? bus.wb_data : regs[addr];
    // The last outstanding write landing this cycle is already visible via bypass.
    assign bus.rd_busy[i] = !cnt_zero[addr] && !(hit && (cnt[addr] == CNT_W'(1)));
  end

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (reset && w_grf_we)
      $display("%s", $sformatf(GRF_TRACE_FMT, bus.wb_pc, bus.wb_addr, bus.wb_data));
    if (reset && !err_underflow && (|cnt_uf))
      $display("grf_scoreboard warning: writeback with no pending write at pc %h", bus.wb_pc);
  end
`else
  // Silent build: no simulation output.
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench for grf_scoreboard against a behavioural register/pending model.
module tb_grf_scoreboard;
  import grf_scoreboard_pkg::*;

  localparam int DATA_W   = 32;
  localparam int REG_NUM  = 32;
  localparam int RD_PORTS = 2;
  localparam int CNT_W    = 2;
  localparam int AW       = 5;
  localparam int MAXC     = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_scoreboard_if #(.DATA_W(DATA_W), .REG_NUM(REG_NUM), .RD_PORTS(RD_PORTS)) bus ();

  logic              err_underflow;
  logic              w_grf_we;
  logic [AW-1:0]     w_grf_addr;
  logic [DATA_W-1:0] w_grf_wdata;
  logic [31:0]       w_inst_addr;

  grf_scoreboard #(.DATA_W(DATA_W), .REG_NUM(REG_NUM), .RD_PORTS(RD_PORTS), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .err_underflow (err_underflow),
    .w_grf_we      (w_grf_we),
    .w_grf_addr    (w_grf_addr),
    .w_grf_wdata   (w_grf_wdata),
    .w_inst_addr   (w_inst_addr)
  );

  logic [31:0] m_reg [REG_NUM];
  int          m_cnt [REG_NUM];
  bit          m_uf;
  int          n_pass = 0;
  int          n_checks = 0;

  function automatic void m_reset();
    for (int i = 0; i < REG_NUM; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_uf = 1'b0;
  endfunction

  function automatic bit m_hit(int a);
    return bus.wb_we && (int'(bus.wb_addr) == a) && (a != 0);
  endfunction

  function automatic logic [31:0] m_rdata(int a);
    return m_hit(a) ? bus.wb_data : m_reg[a];
  endfunction

  function automatic bit m_busy(int a);
    return (a != 0) && (m_cnt[a] != 0) && !(m_hit(a) && m_cnt[a] == 1);
  endfunction

  function automatic bit m_ready();
    int ia = int'(bus.issue_addr);
    return (ia == 0) || (m_cnt[ia] < MAXC) || (bus.wb_we && int'(bus.wb_addr) == ia);
  endfunction

  function automatic void m_edge(bit rdy);
    int ia = int'(bus.issue_addr);
    int wa = int'(bus.wb_addr);
    bit inc = bus.issue_valid && rdy && ia != 0;
    bit dec = bus.wb_we && wa != 0;
    if (dec) m_reg[wa] = bus.wb_data;
    if (bus.flush) begin
      for (int i = 0; i < REG_NUM; i++) m_cnt[i] = 0;
    end else if (!(inc && dec && ia == wa)) begin
      if (inc) m_cnt[ia] = m_cnt[ia] + 1;
      if (dec) begin
        if (m_cnt[wa] == 0) m_uf = 1'b1;
        else m_cnt[wa] = m_cnt[wa] - 1;
      end
    end
  endfunction

  task automatic tick();
    bit rdy;
    rdy = m_ready();
    @(posedge clk);
    m_edge(rdy);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
    bus.wb_we       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.wb_pc       = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic set_rd(int a0, int a1);
    bus.rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic issue_one(int a);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_addr  = AW'(a);
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    set_rd(5, 31);
    bus.issue_addr = AW'(3);
    #1;
    m_reset();
    n_checks++;
    if (err_underflow !== 1'b0) $display("FAIL reset_err: got %b want 0", err_underflow);
    else n_pass++;
    n_checks++;
    if (bus.issue_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.issue_ready);
    else n_pass++;
    n_checks++;
    if (bus.rd_data !== '0 || bus.rd_busy !== '0)
      $display("FAIL reset_read: data %h busy %b want 0/0", bus.rd_data, bus.rd_busy);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    issue_one(5);
    bus.wb_we = 1'b1; bus.wb_addr = AW'(5); bus.wb_data = 32'hDEADBEEF; bus.wb_pc = 32'h100;
    #1;
    n_checks++;
    if (w_grf_we !== 1'b1 || w_grf_addr !== AW'(5) || w_grf_wdata !== 32'hDEADBEEF || w_inst_addr !== 32'h100)
      $display("FAIL trace_wr: we %b addr %0d data %h pc %h", w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr);
    else n_pass++;
    tick();
    idle();
    set_rd(5, 0);
    #1;
    n_checks++;
    if (bus.rd_data[31:0] !== 32'hDEADBEEF || bus.rd_busy[0] !== 1'b0)
      $display("FAIL read_reg5: data %h busy %b want deadbeef/0", bus.rd_data[31:0], bus.rd_busy[0]);
    else n_pass++;
    bus.wb_we = 1'b1; bus.wb_addr = '0; bus.wb_data = 32'hCAFEF00D;
    set_rd(0, 0);
    #1;
    n_checks++;
    if (bus.rd_data[31:0] !== 32'h0 || w_grf_we !== 1'b0)
      $display("FAIL reg0_bypass: data %h trace_we %b want 0/0", bus.rd_data[31:0], w_grf_we);
    else n_pass++;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.rd_data[31:0] !== 32'h0 || bus.rd_busy[0] !== 1'b0 || err_underflow !== 1'b0)
      $display("FAIL reg0_read: data %h busy %b err %b want 0", bus.rd_data[31:0], bus.rd_busy[0], err_underflow);
    else n_pass++;
  endtask

  task automatic test_bypass();
    issue_one(7);
    bus.wb_we = 1'b1; bus.wb_addr = AW'(7); bus.wb_data = 32'h1234;
    set_rd(0, 7);
    #1;
    n_checks++;
    if (bus.rd_data[63:32] !== 32'h1234 || bus.rd_busy[1] !== 1'b0)
      $display("FAIL bypass: data %h busy %b want 1234/0", bus.rd_data[63:32], bus.rd_busy[1]);
    else n_pass++;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.rd_data[63:32] !== 32'h1234 || bus.rd_busy[1] !== 1'b0)
      $display("FAIL bypass_after: data %h busy %b want 1234/0", bus.rd_data[63:32], bus.rd_busy[1]);
    else n_pass++;
  endtask

  task automatic test_saturate();
    set_rd(3, 0);
    for (int k = 0; k < 3; k++) issue_one(3);
    bus.issue_addr = AW'(3);
    #1;
    n_checks++;
    if (bus.issue_ready !== 1'b0 || bus.rd_busy[0] !== 1'b1)
      $display("FAIL sat_full: ready %b busy %b want 0/1", bus.issue_ready, bus.rd_busy[0]);
    else n_pass++;
    issue_one(3);
    for (int k = 0; k < 3; k++) begin
      bus.wb_we = 1'b1; bus.wb_addr = AW'(3); bus.wb_data = 32'h300 + k;
      bus.issue_addr = AW'(3);
      #1;
      n_checks++;
      if (bus.rd_busy[0] !== (k != 2) || bus.issue_ready !== 1'b1)
        $display("FAIL sat_drain%0d: busy %b ready %b want %b/1", k, bus.rd_busy[0], bus.issue_ready, (k != 2));
      else n_pass++;
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b0 || err_underflow !== 1'b0 || bus.rd_data[31:0] !== 32'h302)
      $display("FAIL sat_done: busy %b err %b data %h want 0/0/302", bus.rd_busy[0], err_underflow, bus.rd_data[31:0]);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    issue_one(9);
    set_rd(0, 9);
    bus.issue_valid = 1'b1; bus.issue_addr = AW'(9);
    bus.wb_we = 1'b1; bus.wb_addr = AW'(9); bus.wb_data = 32'h9999;
    #1;
    n_checks++;
    if (bus.rd_busy[1] !== 1'b0 || bus.issue_ready !== 1'b1)
      $display("FAIL simul_same: busy %b ready %b want 0/1", bus.rd_busy[1], bus.issue_ready);
    else n_pass++;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.rd_busy[1] !== 1'b1 || bus.rd_data[63:32] !== 32'h9999)
      $display("FAIL simul_after: busy %b data %h want 1/9999", bus.rd_busy[1], bus.rd_data[63:32]);
    else n_pass++;
    bus.wb_we = 1'b1; bus.wb_addr = AW'(9); bus.wb_data = 32'h999A;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.rd_busy[1] !== 1'b0 || err_underflow !== 1'b0)
      $display("FAIL simul_drain: busy %b err %b want 0/0", bus.rd_busy[1], err_underflow);
    else n_pass++;
  endtask

  task automatic test_underflow();
    bus.wb_we = 1'b1; bus.wb_addr = AW'(4); bus.wb_data = 32'h4444;
    tick();
    idle();
    #1;
    n_checks++;
    if (err_underflow !== 1'b1) $display("FAIL uf_set: got %b want 1", err_underflow);
    else n_pass++;
    for (int k = 0; k < 3; k++) tick();
    n_checks++;
    if (err_underflow !== 1'b1) $display("FAIL uf_sticky: got %b want 1", err_underflow);
    else n_pass++;
    set_rd(5, 4);
    reset = 1'b0;
    #1;
    m_reset();
    n_checks++;
    if (err_underflow !== 1'b0 || bus.rd_data !== '0)
      $display("FAIL uf_async_reset: err %b data %h want 0/0", err_underflow, bus.rd_data);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_flush();
    issue_one(2);
    issue_one(6);
    issue_one(31);
    issue_one(2);
    set_rd(2, 31);
    #1;
    n_checks++;
    if (bus.rd_busy !== 2'b11) $display("FAIL flush_pre: busy %b want 11", bus.rd_busy);
    else n_pass++;
    bus.flush = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_addr = AW'(2);
    bus.wb_we = 1'b1; bus.wb_addr = AW'(10); bus.wb_data = 32'hA5A5A5A5;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.rd_busy !== 2'b00) $display("FAIL flush_clear: busy %b want 00", bus.rd_busy);
    else n_pass++;
    set_rd(6, 10);
    #1;
    n_checks++;
    if (bus.rd_busy !== 2'b00 || bus.rd_data[63:32] !== 32'hA5A5A5A5 || err_underflow !== 1'b0)
      $display("FAIL flush_side: busy %b data %h err %b want 00/a5a5a5a5/0", bus.rd_busy, bus.rd_data[63:32], err_underflow);
    else n_pass++;
  endtask

  task automatic test_random();
    int a0, a1;
    for (int it = 0; it < 400; it++) begin
      a0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      a1 = int'($urandom_range(0, 7));
      set_rd(a0, a1);
      bus.issue_valid = $urandom_range(0, 1) == 1;
      bus.issue_addr  = AW'($urandom_range(0, 7));
      bus.wb_we       = $urandom_range(0, 2) == 0;
      bus.wb_addr     = AW'($urandom_range(0, 7));
      bus.wb_data     = $urandom;
      bus.wb_pc       = $urandom;
      bus.flush       = $urandom_range(0, 15) == 0;
      #1;
      n_checks++;
      if (bus.rd_data[31:0] !== m_rdata(a0) || bus.rd_data[63:32] !== m_rdata(a1))
        $display("FAIL rnd_data it%0d: got %h want %h_%h", it, bus.rd_data, m_rdata(a1), m_rdata(a0));
      else n_pass++;
      n_checks++;
      if (bus.rd_busy !== {m_busy(a1), m_busy(a0)} || bus.issue_ready !== m_ready())
        $display("FAIL rnd_busy it%0d: busy %b ready %b want %b%b/%b", it, bus.rd_busy, bus.issue_ready,
                 m_busy(a1), m_busy(a0), m_ready());
      else n_pass++;
      n_checks++;
      if (w_grf_we !== (bus.wb_we && bus.wb_addr != 0) || w_grf_addr !== bus.wb_addr ||
          w_grf_wdata !== bus.wb_data || w_inst_addr !== bus.wb_pc)
        $display("FAIL rnd_trace it%0d: we %b addr %0d", it, w_grf_we, w_grf_addr);
      else n_pass++;
      tick();
      n_checks++;
      if (err_underflow !== m_uf) $display("FAIL rnd_err it%0d: got %b want %b", it, err_underflow, m_uf);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    set_rd(0, 0);
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_bypass();
    test_saturate();
    test_simultaneous();
    test_underflow();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
